// File: rtl/shift_unit.sv
// Multi-cycle barrel-lite shifter: shifts the captured operand by up to STEP
// bit positions per clock until the requested amount is consumed.
module shift_unit #(
    parameter int WIDTH   = 32,
    parameter int STEP    = 4,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    op_t                op_q;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   shifted;
    logic [SHAMT_W-1:0] remaining;
    logic [SHAMT_W-1:0] step_k;

    assign busy = (state == SHIFT);

    // Per-cycle amount is min(STEP, remaining); never exceeds remaining, so no underflow.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        step_k  = remaining;
        shifted = work;
        if (remaining > SHAMT_W'(STEP)) begin
            step_k = SHAMT_W'(STEP);
        end
        unique case (op_q)
            OP_SLL: shifted = work << step_k;
            OP_SRL: shifted = work >> step_k;
            OP_SRA: shifted = $signed(work) >>> step_k;
            OP_ROL: shifted = (work << step_k) | (work >> (WIDTH - int'(step_k)));
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_SLL;
            work      <= '0;
            remaining <= '0;
            dout      <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // Abort wins over capture and completion alike.
                state     <= IDLE;
                remaining <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            work      <= din;
                            op_q      <= op_t'(op);
                            remaining <= shamt;
                            state     <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (remaining != '0) begin
                            work      <= shifted;
                            remaining <= remaining - step_k;
                        end else begin
                            dout  <= work;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed literal cases plus random
// traffic compared every cycle against a transaction-level model.
module tb_shift_unit;

    localparam int WIDTH   = 32;
    localparam int STEP    = 4;
    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [1:0]         op = 2'b00;
    logic [WIDTH-1:0]   din = '0;
    logic [SHAMT_W-1:0] shamt = '0;
    logic               flush = 1'b0;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   dout;

    int n_checks = 0;
    int n_fail   = 0;

    shift_unit #(.WIDTH(WIDTH), .STEP(STEP), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .din   (din),
        .shamt (shamt),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-shift result straight from the operation definitions.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int s);
        logic signed [31:0] sd;
        sd = d;
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'(sd >>> s);
            default: return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
        endcase
    endfunction

    // Transaction model: a captured op completes ceil(shamt/STEP)+1 edges later.
    logic        m_busy;
    logic        m_done;
    logic [31:0] m_dout;
    logic [31:0] m_res;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dout <= '0;
            m_res  <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (flush) begin
                m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_left <= (int'(shamt) + STEP - 1) / STEP;
                    m_res  <= ref_shift(op, din, int'(shamt));
                end
            end else if (m_left == 0) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_dout <= m_res;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy_vs_model", 32'(busy), 32'(m_busy));
        check("done_vs_model", 32'(done), 32'(m_done));
        check("dout_vs_model", dout, m_dout);
    end

    task automatic start_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        din   = d;
        shamt = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
        check("done_timeout", 32'(done), 32'd1);
    endtask

    int cyc;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dout", dout, 32'h0);
        rst_n = 1'b1;

        // SLL 1 by 31: busy through 8 shift edges, done after edge k+9.
        start_op(2'b00, 32'h0000_0001, 5'd31);
        check("sll31_busy_after_capture", 32'(busy), 32'd1);
        wait_done(cyc);
        check("sll31_latency", 32'(cyc), 32'd9);
        check("sll31_dout", dout, 32'h8000_0000);
        @(negedge clk);
        check("sll31_done_one_cycle", 32'(done), 32'd0);

        start_op(2'b10, 32'h8000_0000, 5'd4);
        wait_done(cyc);
        check("sra4_latency", 32'(cyc), 32'd2);
        check("sra4_dout", dout, 32'hF800_0000);

        start_op(2'b01, 32'h8000_0000, 5'd4);
        wait_done(cyc);
        check("srl4_dout", dout, 32'h0800_0000);

        start_op(2'b11, 32'h8000_0001, 5'd1);
        wait_done(cyc);
        check("rol1_dout", dout, 32'h0000_0003);

        start_op(2'b00, 32'h1234_5678, 5'd0);
        wait_done(cyc);
        check("shamt0_latency", 32'(cyc), 32'd1);
        check("shamt0_dout", dout, 32'h1234_5678);

        // Start while busy is ignored; captured operands and op stay intact.
        start_op(2'b00, 32'h0000_000F, 5'd8);
        start = 1'b1; op = 2'b01; din = 32'hFFFF_FFFF; shamt = 5'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("ignored_start_dout", dout, 32'h0000_0F00);

        // Flush mid-shift: no completion, dout keeps the prior result.
        start_op(2'b00, 32'h0000_0001, 5'd20);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_cleared", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("flush_no_done", 32'(done), 32'd0);
        end
        check("flush_dout_held", dout, 32'h0000_0F00);

        // Flush with start in idle discards the start.
        start = 1'b1; flush = 1'b1; op = 2'b00; din = 32'h1; shamt = 5'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", 32'(busy), 32'd0);

        // Back-to-back: start issued in the done cycle is captured with no gap.
        start_op(2'b01, 32'hF000_0000, 5'd8);
        wait_done(cyc);
        check("b2b_first_dout", dout, 32'h00F0_0000);
        start = 1'b1; op = 2'b11; din = 32'h0000_00F0; shamt = 5'd28;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_gap_busy", 32'(busy), 32'd1);
        wait_done(cyc);
        check("b2b_second_dout", dout, 32'h0000_000F);

        // Asynchronous reset mid-shift.
        start_op(2'b01, 32'hDEAD_BEEF, 5'd31);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_dout", dout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_no_done", 32'(done), 32'd0);
        end
        start_op(2'b00, 32'h0000_0003, 5'd2);
        check("post_rst_accepts", 32'(busy), 32'd1);
        wait_done(cyc);
        check("post_rst_dout", dout, 32'h0000_000C);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 19) == 0);
            op    = 2'($urandom);
            din   = $urandom;
            shamt = 5'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 The parameter WIDTH SHALL default to 32 and set the datapath width; it is a power of 2 and at least 8.
REQ-002 The parameter STEP SHALL default to 4 and set the maximum bit positions shifted per cycle; it is a power of 2 from 1 to WIDTH/2.
REQ-003 The parameter SHAMT_W SHALL default to 5 and equal clog2(WIDTH).
REQ-004 The port clk SHALL be a 1-bit input and the single clock; all state changes on its rising edge.
REQ-005 The port rst_n SHALL be a 1-bit input providing an asynchronous, active-low reset.
REQ-006 The port start SHALL be a 1-bit input that requests an operation; it is sampled only while busy=0.
REQ-007 The port op SHALL be a 2-bit input selecting the operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-008 The port din SHALL be a WIDTH-bit input carrying the operand.
REQ-009 The port shamt SHALL be a SHAMT_W-bit unsigned input carrying the shift amount.
REQ-010 The port flush SHALL be a 1-bit input that synchronously aborts any in-flight operation.
REQ-011 The port busy SHALL be a 1-bit output that is high while an operation is in flight.
REQ-012 The port done SHALL be a 1-bit output that pulses for one cycle when a result is written to dout.
REQ-013 The port dout SHALL be a WIDTH-bit output carrying the last completed result, held until the next completion.

Function
REQ-014 The block SHALL implement two states: IDLE (busy=0) and SHIFT (busy=1).
REQ-015 In IDLE with start=1 and flush=0, the block SHALL capture din, op and shamt into internal registers (remaining<=shamt) and enter SHIFT on that edge.
REQ-016 In SHIFT with remaining>0, each edge SHALL shift the working register by k=min(STEP, remaining) per op and set remaining<=remaining-k.
REQ-017 SLL SHALL fill with zeros; SRL SHALL fill with zeros; SRA SHALL fill with working-register bit WIDTH-1; ROL SHALL rotate left, with bits leaving the MSB entering the LSB.
REQ-018 In SHIFT with remaining=0, the edge SHALL load dout with the working register, assert done for the following cycle only, and return to IDLE.
REQ-019 Latency from the start-capture edge to the dout-update edge SHALL be ceil(shamt/STEP)+1 edges; shamt=0 completes in 1 edge with dout=din.
REQ-020 start SHALL be ignored while busy=1; no queuing or overwrite of captured operands occurs.
REQ-021 busy SHALL be 0 during the done cycle, so a start in that cycle is accepted.
REQ-022 flush=1 on an edge SHALL force IDLE and clear remaining; no done pulse and no dout update occur for the aborted operation.
REQ-023 flush=1 together with start=1 in IDLE SHALL leave the block in IDLE with the start discarded.
REQ-024 op and shamt changes after the capture edge SHALL NOT affect the in-flight result.
REQ-025 All arithmetic SHALL be unsigned except the SRA sign fill; remaining SHALL never underflow.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, set the state to IDLE, busy=0, done=0, dout=0, and clear the working register and remaining.
REQ-027 Reset asserted mid-operation SHALL abandon it; after release the block is idle and accepts start on the first edge.

Verification (WIDTH=32, STEP=4)
REQ-028 SLL with din=0x00000001 and shamt=31, start at edge k -> busy is high after edges k..k+8, done is high for one cycle after edge k+9, and dout=0x80000000.
REQ-029 SRA with din=0x80000000 and shamt=4 -> dout=0xF8000000 after 2 edges; SRL with the same operands -> dout=0x08000000.
REQ-030 ROL with din=0x80000001 and shamt=1 -> dout=0x00000003; SLL with din=0x12345678 and shamt=0 -> dout=0x12345678 one edge after capture.
REQ-031 A start during busy with different din -> ignored, and the original result is produced; flush mid-SHIFT -> no done pulse, dout retains its prior value, and busy=0 on the next cycle.
REQ-032 A start in the done cycle -> the new operation is captured with no idle gap, and both results appear in order.
REQ-033 rst_n pulsed low mid-SHIFT -> outputs clear asynchronously, with no done pulse after release.
